// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment patterns
// ({g,f,e,d,c,b,a}), the blank pattern and the anode-off level.
package seg_pkg;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] segCode_t;

   localparam segCode_t SEG_0 = 7'b1000000;
   localparam segCode_t SEG_1 = 7'b1111001;
   localparam segCode_t SEG_2 = 7'b0100100;
   localparam segCode_t SEG_3 = 7'b0110000;
   localparam segCode_t SEG_4 = 7'b0011001;
   localparam segCode_t SEG_5 = 7'b0010010;
   localparam segCode_t SEG_6 = 7'b0000010;
   localparam segCode_t SEG_7 = 7'b1111000;
   localparam segCode_t SEG_8 = 7'b0000000;
   localparam segCode_t SEG_9 = 7'b0010000;
   localparam segCode_t SEG_A = 7'b0001000;
   localparam segCode_t SEG_B = 7'b0000011;
   localparam segCode_t SEG_C = 7'b1000110;
   localparam segCode_t SEG_D = 7'b0100001;
   localparam segCode_t SEG_E = 7'b0000110;
   localparam segCode_t SEG_F = 7'b0001110;

   localparam segCode_t SEG_BLANK = 7'h7F;

   // Anodes are active-low, so a high level switches a digit off.
   localparam logic ANODE_OFF = 1'b1;

endpackage

// File: rtl/seg_scan_display_if.sv
// Bus between the producing datapath and the seven-segment scanner.
// master drives value/load/dotMask/enable; slave (the scanner) drives the pins.
interface seg_scan_display_if #(
   parameter int DIGITS = 4
) ();

   logic [4*DIGITS-1:0] value;
   logic                load;
   logic [DIGITS-1:0]   dotMask;
   logic                enable;
   logic [DIGITS-1:0]   anode;
   logic [6:0]          segment;
   logic                dp;
   logic                scanTick;
   logic [4*DIGITS-1:0] shown;

   modport master (
      output value, load, dotMask, enable,
      input  anode, segment, dp, scanTick, shown
   );

   modport slave (
      input  value, load, dotMask, enable,
      output anode, segment, dp, scanTick, shown
   );

endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
   import seg_pkg::*;
(
   input  nibble_t  nibble,
   output segCode_t segment
);

   always_comb begin
      segment = SEG_BLANK;
      unique case (nibble)
         4'h0: segment = SEG_0;
         4'h1: segment = SEG_1;
         4'h2: segment = SEG_2;
         4'h3: segment = SEG_3;
         4'h4: segment = SEG_4;
         4'h5: segment = SEG_5;
         4'h6: segment = SEG_6;
         4'h7: segment = SEG_7;
         4'h8: segment = SEG_8;
         4'h9: segment = SEG_9;
         4'hA: segment = SEG_A;
         4'hB: segment = SEG_B;
         4'hC: segment = SEG_C;
         4'hD: segment = SEG_D;
         4'hE: segment = SEG_E;
         4'hF: segment = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scanner with a load-captured value.
// Define SEG_LEADING_ZERO_BLANK_EN to blank digits above the most significant non-zero nibble.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV_W = 16
) (
   input logic               mainClock,
   input logic               reset,
   seg_scan_display_if.slave bus
);

   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   logic [SCAN_DIV_W-1:0] prescalerReg;
   logic [IDX_W-1:0]      indexReg;
   logic [4*DIGITS-1:0]   shownReg;
   logic                  scanTickReg;
   logic [DIGITS-1:0]     anodeReg;
   segCode_t              segmentReg;
   logic                  dpReg;

   logic                  advance;
   nibble_t               currentNibble;
   segCode_t              decodedSeg;
   logic [DIGITS-1:0]     blankMask;
   logic [DIGITS-1:0]     anodeOneCold;
   logic [DIGITS-1:0]     anodeNext;
   segCode_t              segmentNext;

   assign advance       = &prescalerReg;
   assign currentNibble = shownReg[{indexReg, 2'b00} +: 4];

   hex_to_seg decoder (
      .nibble  (currentNibble),
      .segment (decodedSeg)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : genAnode
         assign anodeOneCold[gi] = (indexReg != IDX_W'(gi));
      end
   endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // upperZero[i]: nibble i and every nibble above it are zero; digit 0 never blanks.
   logic [DIGITS:1] upperZero;
   assign upperZero[DIGITS] = 1'b1;
   assign blankMask[0]      = 1'b0;
   generate
      for (gi = 1; gi < DIGITS; gi++) begin : genBlank
         assign upperZero[gi] = (shownReg[4*gi +: 4] == 4'h0) && upperZero[gi+1];
         assign blankMask[gi] = upperZero[gi];
      end
   endgenerate
`else
   assign blankMask = '0;
`endif

   assign anodeNext   = bus.enable ? anodeOneCold : {DIGITS{ANODE_OFF}};
   assign segmentNext = blankMask[indexReg] ? SEG_BLANK : decodedSeg;

   always_ff @(posedge mainClock or negedge reset) begin
      if (!reset) begin
         prescalerReg <= '0;
         indexReg     <= '0;
         shownReg     <= '0;
         scanTickReg  <= 1'b0;
         anodeReg     <= {DIGITS{ANODE_OFF}};
         segmentReg   <= SEG_BLANK;
         dpReg        <= 1'b1;
      end else begin
         prescalerReg <= advance ? '0 : prescalerReg + 1'b1;
         scanTickReg  <= advance;
         if (advance) begin
            indexReg <= (indexReg == LAST_IDX) ? '0 : indexReg + 1'b1;
         end
         if (bus.load) begin
            shownReg <= bus.value;
         end
         // Pins follow the index that was current before this edge.
         anodeReg   <= anodeNext;
         segmentReg <= segmentNext;
         dpReg      <= ~bus.dotMask[indexReg];
      end
   end

   assign bus.anode    = anodeReg;
   assign bus.segment  = segmentReg;
   assign bus.dp       = dpReg;
   assign bus.scanTick = scanTickReg;
   assign bus.shown    = shownReg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (DIGITS=4, SCAN_DIV_W=2) with a per-cycle scoreboard.
module tb_seg_scan_display;

   localparam int DIGITS     = 4;
   localparam int SCAN_DIV_W = 2;

`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef struct {
      logic [3:0]  anode;
      logic [6:0]  segment;
      logic        dp;
      logic        scanTick;
      logic [15:0] shown;
   } exp_t;

   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   seg_scan_display_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_display #(.DIGITS(DIGITS), .SCAN_DIV_W(SCAN_DIV_W)) dut (
      .mainClock (clk),
      .reset     (rstN),
      .bus       (bus)
   );

   exp_t        sb[$];
   int          mN;
   logic [15:0] mShown;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [6:0] refSeg(logic [15:0] s, int idx);
      logic [15:0] upper;
      logic [3:0]  nib;
      upper = s >> (4 * idx);
      nib   = upper[3:0];
      if (BLANK_EN && idx > 0 && upper == 16'h0) return 7'h7F;
      return SEG_TABLE[nib];
   endfunction

   // One clock: push expected pin state, let the edge happen, pop and compare.
   task automatic tick();
      exp_t e;
      int   idx;
      idx        = (mN / 4) % 4;
      e.anode    = bus.enable ? ~(4'b0001 << idx) : 4'hF;
      e.segment  = refSeg(mShown, idx);
      e.dp       = ~bus.dotMask[idx];
      e.scanTick = ((mN + 1) % 4 == 0);
      e.shown    = bus.load ? bus.value : mShown;
      mShown     = e.shown;
      mN++;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.anode !== e.anode) begin
         errors++; $display("FAIL sb_anode edge %0d: got %b expected %b", mN, bus.anode, e.anode);
      end
      checks++;
      if (bus.segment !== e.segment) begin
         errors++; $display("FAIL sb_segment edge %0d: got %b expected %b", mN, bus.segment, e.segment);
      end
      checks++;
      if (bus.dp !== e.dp) begin
         errors++; $display("FAIL sb_dp edge %0d: got %b expected %b", mN, bus.dp, e.dp);
      end
      checks++;
      if (bus.scanTick !== e.scanTick) begin
         errors++; $display("FAIL sb_scanTick edge %0d: got %b expected %b", mN, bus.scanTick, e.scanTick);
      end
      checks++;
      if (bus.shown !== e.shown) begin
         errors++; $display("FAIL sb_shown edge %0d: got %h expected %h", mN, bus.shown, e.shown);
      end
      $display("edge %0d anode=%b segment=%b dp=%b scanTick=%b shown=%h",
               mN, bus.anode, bus.segment, bus.dp, bus.scanTick, bus.shown);
   endtask

   task automatic test_reset();
      logic expTick;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.anode !== 4'hF || bus.segment !== 7'h7F || bus.dp !== 1'b1 ||
          bus.scanTick !== 1'b0 || bus.shown !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: got anode=%b seg=%b dp=%b tick=%b shown=%h expected 1111 1111111 1 0 0000",
                  bus.anode, bus.segment, bus.dp, bus.scanTick, bus.shown);
      end
      rstN = 1'b1; mN = 0; mShown = 16'h0;
      for (int k = 1; k <= 4; k++) begin
         bus.load  = (k == 1);
         bus.value = 16'h5555;
         tick();
         expTick = (k == 4);
         checks++;
         if (bus.scanTick !== expTick) begin
            errors++; $display("FAIL first_tick edge %0d: got %b expected %b", k, bus.scanTick, expTick);
         end
      end
      // Mid-scan reset with a load pending: everything clears at once, load is lost.
      bus.load = 1'b1; bus.value = 16'hABCD;
      #2 rstN = 1'b0;
      #1;
      checks++;
      if (bus.anode !== 4'hF || bus.segment !== 7'h7F || bus.dp !== 1'b1 || bus.shown !== 16'h0) begin
         errors++;
         $display("FAIL async_reset: got anode=%b seg=%b dp=%b shown=%h expected 1111 1111111 1 0000",
                  bus.anode, bus.segment, bus.dp, bus.shown);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.shown !== 16'h0) begin
         errors++; $display("FAIL load_discarded: got %h expected 0000", bus.shown);
      end
      bus.load = 1'b0;
      rstN = 1'b1; mN = 0; mShown = 16'h0;
   endtask

   task automatic test_scan_order();
      logic [3:0] expAnode [4];
      logic [6:0] expSeg   [4];
      int         idx;
      expAnode = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      expSeg   = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
      bus.load = 1'b1; bus.value = 16'h1234;
      tick();
      bus.load = 1'b0;
      for (int n = 2; n <= 20; n++) begin
         tick();
         if (n >= 5) begin
            idx = ((n - 1) / 4) % 4;
            checks++;
            if (bus.anode !== expAnode[idx] || bus.segment !== expSeg[idx]) begin
               errors++;
               $display("FAIL scan_order edge %0d: got %b/%b expected %b/%b",
                        n, bus.anode, bus.segment, expAnode[idx], expSeg[idx]);
            end
         end
      end
   endtask

   task automatic test_load_latency();
      while (mN % 16 != 0) tick();
      bus.load = 1'b1; bus.value = 16'hF00F;
      tick();
      bus.load = 1'b0;
      checks++;
      if (bus.shown !== 16'hF00F) begin
         errors++; $display("FAIL load_shown: got %h expected F00F", bus.shown);
      end
      tick();
      checks++;
      if (bus.segment !== 7'b0001110 || bus.anode !== 4'b1110) begin
         errors++; $display("FAIL load_segment: got %b/%b expected 1110/0001110", bus.anode, bus.segment);
      end
   endtask

   task automatic test_enable_dp();
      int ticks = 0;
      logic dpLow, digit2;
      bus.dotMask = 4'b0100; bus.enable = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.scanTick === 1'b1) ticks++;
         checks++;
         if (bus.anode !== 4'hF) begin
            errors++; $display("FAIL disabled_anode: got %b expected 1111", bus.anode);
         end
      end
      checks++;
      if (ticks != 2) begin
         errors++; $display("FAIL disabled_scanTick: got %0d pulses expected 2", ticks);
      end
      bus.enable = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         dpLow  = (bus.dp === 1'b0);
         digit2 = (bus.anode === 4'b1011);
         checks++;
         if (dpLow !== digit2) begin
            errors++; $display("FAIL dp_digit2: got dp=%b anode=%b expected dp low only with 1011", bus.dp, bus.anode);
         end
      end
      bus.dotMask = 4'b0000;
   endtask

   task automatic test_blanking();
      logic [6:0] zeroOrBlank, want;
      zeroOrBlank = BLANK_EN ? 7'h7F : 7'b1000000;
      bus.load = 1'b1; bus.value = 16'h0050;
      tick();
      bus.load = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         case (bus.anode)
            4'b0111, 4'b1011: want = zeroOrBlank;
            4'b1101:          want = 7'b0010010;
            default:          want = 7'b1000000;
         endcase
         checks++;
         if (bus.segment !== want) begin
            errors++; $display("FAIL blank_0050 anode %b: got %b expected %b", bus.anode, bus.segment, want);
         end
      end
      bus.load = 1'b1; bus.value = 16'h0000;
      tick();
      bus.load = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         want = (bus.anode === 4'b1110) ? 7'b1000000 : zeroOrBlank;
         checks++;
         if (bus.segment !== want) begin
            errors++; $display("FAIL blank_0000 anode %b: got %b expected %b", bus.anode, bus.segment, want);
         end
      end
   endtask

   task automatic test_simul_load();
      logic [15:0] v, sh;
      logic [6:0]  want;
      int          idx;
      v = 16'h9876;
      while (mN % 4 != 3) tick();
      bus.load = 1'b1; bus.value = v;
      tick();
      bus.load = 1'b0;
      checks++;
      if (bus.scanTick !== 1'b1 || bus.shown !== v) begin
         errors++; $display("FAIL simul_advance: got tick=%b shown=%h expected 1 %h", bus.scanTick, bus.shown, v);
      end
      tick();
      idx  = ((mN - 1) / 4) % 4;
      sh   = v >> (4 * idx);
      want = SEG_TABLE[sh[3:0]];
      checks++;
      if (bus.segment !== want) begin
         errors++; $display("FAIL simul_segment digit %0d: got %b expected %b", idx, bus.segment, want);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] v;
      bus.dotMask = 4'b1010;
      for (int k = 0; k < 12; k++) begin
         v = 16'($urandom_range(0, 65535));
         bus.load = 1'b1; bus.value = v;
         tick();
         checks++;
         if (bus.shown !== v) begin
            errors++; $display("FAIL back_to_back %0d: got %h expected %h", k, bus.shown, v);
         end
      end
      bus.load = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      rstN        = 1'b0;
      bus.value   = 16'h0;
      bus.load    = 1'b0;
      bus.dotMask = 4'b0000;
      bus.enable  = 1'b1;
      mN          = 0;
      mShown      = 16'h0;
      test_reset();
      test_scan_order();
      test_load_latency();
      test_enable_dp();
      test_blanking();
      test_simul_load();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Multiplexed seven-segment display driver for the lab board. It reads a packed hex value, such as the 4-bit down-counter output, and drives a bank of common-anode digits one at a time at a refresh rate divided down from `mainClock`. The value is captured under a `load` strobe so the producing logic may change its count freely between loads. The block sits between the counting/datapath logic and the board's anode/segment pins.

## Interface
- `DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `SCAN_DIV_W`, default 16: prescaler width; the digit advances every 2^SCAN_DIV_W cycles.
- `mainClock` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `value` in 4*DIGITS: hex nibbles; nibble i (bits 4i+3:4i) goes to digit i, and digit 0 is rightmost.
- `load` in 1: when high at a clock edge, `value` is captured.
- `dotMask` in DIGITS: bit i high lights the decimal point of digit i; not latched.
- `enable` in 1: when low, all anodes are off; scanning continues.
- `anode` out DIGITS: active-low, at most one bit low.
- `segment` out 7: active-low, bit order {g,f,e,d,c,b,a}.
- `dp` out 1: active-low decimal point.
- `scanTick` out 1: one-cycle pulse on each digit advance.
- `shown` out 4*DIGITS: the currently latched value.

## Operation
- Prescaler `p` (SCAN_DIV_W bits) increments every cycle.
- On the edge where `p` is all ones:
  - `p` wraps to 0.
  - The digit index advances; DIGITS-1 wraps to 0.
  - `scanTick` is registered high for exactly one cycle.
- Capture: `load`=1 at edge N makes `shown` = `value` after edge N. With `load`=0, `shown` holds.
- Outputs are registered from the current index, `shown`, `dotMask` and `enable`:
  - `anode` is one-cold at the index position.
  - `segment` = decode(nibble[index]).
  - `dp` = ~dotMask[index].
- Decode is full hex 0–F, active-low. Examples:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - F → 7'b0001110
- `enable`=0: `anode` = all ones from the next edge. The index and `p` keep running, so re-enable resumes mid-sequence with no restart.
- A `load` coinciding with a digit advance: the new digit shows the new value.
- Reset, including mid-scan or mid-load:
  - `p`=0, index=0, `shown`=0, `anode`=all ones, `segment`=7'h7F, `dp`=1, `scanTick`=0.
  - An in-flight `load` is discarded.

## Timing
- `load` to `shown`: 1 cycle.
- `load` to `segment` reflecting the new value for the selected digit: 2 cycles.
- Index change to `anode`/`segment`/`dp`: 1 cycle. `anode` and `segment` change on the same edge.
- First digit advance after reset release: 2^SCAN_DIV_W edges.
- Full refresh period: DIGITS × 2^SCAN_DIV_W cycles.
- Outputs are fully registered, with no combinational path from inputs to pins.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN`, if defined:
  - Digits above the most significant non-zero nibble of `shown` output `segment`=7'h7F while their anode still goes low, which preserves duty cycle.
  - Digit 0 is never blanked, so value 0 displays "0".
  - `dp` is unaffected by blanking.
- Undefined: every digit shows its nibble, including leading zeros.

## Structure
- Shared package `seg_pkg`:
  - Segment pattern constants for 0–F.
  - `SEG_BLANK` = 7'h7F.
  - The active-low anode-off constant.
- One sub-module, `hex_to_seg`: a purely combinational nibble-to-7-bit decoder, instantiated once on the muxed nibble.
- Prescaler, index counter, capture register and output registers live in the top level.

## Test plan
Run all scenarios with SCAN_DIV_W=2 and DIGITS=4.
- **Reset:** assert `reset`=0 mid-scan → `anode`=4'b1111, `segment`=7'h7F, `dp`=1, `shown`=0 immediately. After release, the first `scanTick` arrives 4 edges later.
- **Scan order:** load 16'h1234 and let it run 16 cycles → `anode` sequence 1110, 1101, 1011, 0111, each held 4 cycles. Segments read 4 then 3, 2, 1 (7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001).
- **Load latency:** with index 0 selected, load 16'hF00F → `shown`=16'hF00F after 1 edge; `segment`=7'b0001110 after 2 edges.
- **Enable and decimal point:** set `dotMask`=4'b0100 and `enable`=0 for 8 cycles → `anode`=1111 throughout and `scanTick` still pulses. Re-enable → `dp`=0 only while `anode`=1011.
- **Leading-zero blanking:** with the macro defined, load 16'h0050 → digits 3 and 2 give `segment`=7'h7F, digit 1 shows 5, digit 0 shows "0". Load 0 → only digit 0 lit, showing "0".
- **Simultaneous load and advance:** assert `load` on the `scanTick` edge → the newly selected digit shows the new nibble one cycle later, with no stale-value cycle.
